// File: rtl/prog_seq_pkg.sv
// Shared types and constants for program_sequencer and its instruction store.
package prog_seq_pkg;

  // Default instruction width; matches simple_processor program_in.
  localparam int unsigned INSTR_W_DEFAULT = 23;

  typedef logic [INSTR_W_DEFAULT-1:0] instr_t;

  typedef enum logic [2:0] {
    StIdle,
    StReady,
    StXfer,
    StStart,
    StRun,
    StDone
  } prog_seq_state_t;

endpackage

// File: rtl/prog_seq_store.sv
// Instruction store: DEPTH x DATA_W register array, one synchronous write port,
// one asynchronous read port. Contents are not reset; prog_len qualifies validity.
module prog_seq_store #(
  parameter int unsigned DATA_W = 23,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned AW     = 4
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Capture one host instruction per accepted load.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/program_sequencer.sv
// Sequencing controller in front of simple_processor: buffers a host program,
// streams it into the processor on request, pulses start and waits for done.
// Optional watchdog on the RUN state is enabled by defining PROG_SEQ_TIMEOUT_EN.
module program_sequencer
  import prog_seq_pkg::*;
#(
  parameter int unsigned INSTR_W        = INSTR_W_DEFAULT,
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned CNT_W          = 5,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_clear,
  input  logic               i_load_valid,
  input  logic [INSTR_W-1:0] i_load_instr,
  input  logic               i_load_last,
  output logic               o_load_ready,
  input  logic               i_run_req,
  output logic               o_proc_write,
  output logic [INSTR_W-1:0] o_proc_instr,
  output logic               o_proc_start,
  input  logic               i_proc_done,
  output logic [CNT_W-1:0]   o_prog_len,
  output logic               o_seq_ready,
  output logic               o_done,
  output logic               o_trunc,
  output logic               o_timeout
);

  localparam int unsigned    AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DepthLen = CNT_W'(DEPTH);

  prog_seq_state_t    r_state, w_state_next;
  logic [CNT_W-1:0]   r_prog_len, w_prog_len_next;
  logic [CNT_W-1:0]   r_rd_ptr, w_rd_ptr_next;
  logic               r_trunc, w_trunc_next;
  logic               r_load_ready, r_seq_ready, r_proc_write, r_proc_start, r_done;
  logic               w_proc_write_next, w_proc_start_next, w_done_next;
  logic [INSTR_W-1:0] r_proc_instr, w_proc_instr_next;
  logic               w_accept;
  logic [AW-1:0]      w_rd_addr;
  logic [INSTR_W-1:0] w_rd_data;

`ifdef PROG_SEQ_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_tmo_cnt, w_tmo_cnt_next;
  logic          r_timeout, w_timeout_next;
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CYCLES == 0);
`endif

  // Read address is 0 on the READY->XFER edge so the first word is ready immediately.
  assign w_rd_addr = (r_state == StXfer) ? r_rd_ptr[AW-1:0] : '0;

  prog_seq_store #(
    .DATA_W (INSTR_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_store (
    .i_clk   (i_clk),
    .i_we    (w_accept),
    .i_waddr (r_prog_len[AW-1:0]),
    .i_wdata (i_load_instr),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rd_data)
  );

  // Next-state, counters, flags and next values of the registered outputs.
  always_comb begin
    w_state_next      = r_state;
    w_prog_len_next   = r_prog_len;
    w_rd_ptr_next     = r_rd_ptr;
    w_trunc_next      = r_trunc;
    w_proc_write_next = 1'b0;
    w_proc_instr_next = '0;
    w_proc_start_next = 1'b0;
    w_done_next       = 1'b0;
    w_accept          = 1'b0;
`ifdef PROG_SEQ_TIMEOUT_EN
    w_tmo_cnt_next    = r_tmo_cnt;
    w_timeout_next    = r_timeout;
`endif
    if (i_clear) begin
      w_state_next    = StIdle;
      w_prog_len_next = '0;
      w_rd_ptr_next   = '0;
      w_trunc_next    = 1'b0;
`ifdef PROG_SEQ_TIMEOUT_EN
      w_tmo_cnt_next  = '0;
      w_timeout_next  = 1'b0;
`endif
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_load_valid && r_load_ready) begin
            w_accept        = 1'b1;
            w_prog_len_next = r_prog_len + CNT_W'(1);
            if (i_load_last) begin
              w_state_next = StReady;
            end else if (r_prog_len == DepthLen - CNT_W'(1)) begin
              w_state_next = StReady;
              w_trunc_next = 1'b1;
            end
          end
        end
        StReady: begin
          if (i_run_req) begin
            // Entry 0 is emitted on this edge, so the pointer restarts at 1.
            w_state_next      = StXfer;
            w_proc_write_next = 1'b1;
            w_proc_instr_next = w_rd_data;
            w_rd_ptr_next     = CNT_W'(1);
          end
        end
        StXfer: begin
          if (r_rd_ptr == r_prog_len) begin
            w_state_next      = StStart;
            w_proc_start_next = 1'b1;
          end else begin
            w_proc_write_next = 1'b1;
            w_proc_instr_next = w_rd_data;
            w_rd_ptr_next     = r_rd_ptr + CNT_W'(1);
          end
        end
        StStart: begin
          w_state_next = StRun;
`ifdef PROG_SEQ_TIMEOUT_EN
          w_tmo_cnt_next = '0;
`endif
        end
        StRun: begin
          if (i_proc_done) begin
            w_state_next = StDone;
            w_done_next  = 1'b1;
`ifdef PROG_SEQ_TIMEOUT_EN
          end else if (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            w_state_next   = StReady;
            w_timeout_next = 1'b1;
          end else begin
            w_tmo_cnt_next = r_tmo_cnt + TW'(1);
`endif
          end
        end
        StDone: begin
          w_state_next = StReady;
        end
        default: begin
          w_state_next = StIdle;
        end
      endcase
    end
  end

  // State, counters, flags and all outputs registered; reset dominates clear.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= StIdle;
      r_prog_len   <= '0;
      r_rd_ptr     <= '0;
      r_trunc      <= 1'b0;
      r_load_ready <= 1'b1;
      r_seq_ready  <= 1'b0;
      r_proc_write <= 1'b0;
      r_proc_instr <= '0;
      r_proc_start <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_prog_len   <= w_prog_len_next;
      r_rd_ptr     <= w_rd_ptr_next;
      r_trunc      <= w_trunc_next;
      r_load_ready <= (w_state_next == StIdle);
      r_seq_ready  <= (w_state_next == StReady);
      r_proc_write <= w_proc_write_next;
      r_proc_instr <= w_proc_instr_next;
      r_proc_start <= w_proc_start_next;
      r_done       <= w_done_next;
    end
  end

`ifdef PROG_SEQ_TIMEOUT_EN
  // Watchdog counter and sticky timeout flag.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_tmo_cnt <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_tmo_cnt <= w_tmo_cnt_next;
      r_timeout <= w_timeout_next;
    end
  end
  assign o_timeout = r_timeout;
`else
  assign o_timeout = 1'b0;
`endif

  assign o_load_ready = r_load_ready;
  assign o_seq_ready  = r_seq_ready;
  assign o_proc_write = r_proc_write;
  assign o_proc_instr = r_proc_instr;
  assign o_proc_start = r_proc_start;
  assign o_done       = r_done;
  assign o_prog_len   = r_prog_len;
  assign o_trunc      = r_trunc;

endmodule

// File: tb/tb_program_sequencer.sv
// Self-checking bench for program_sequencer: load/run, replay, truncation,
// clear during transfer, ignored inputs, reset during run, optional watchdog.
module tb_program_sequencer;

  localparam int unsigned IW = 23;

  logic          clk;
  logic          reset, clear, load_valid, load_last, run_req, proc_done;
  logic [IW-1:0] load_instr;
  logic          load_ready, proc_write, proc_start, seq_ready, done, trunc, timeout;
  logic [IW-1:0] proc_instr;
  logic [4:0]    prog_len;

  int checks;
  int failures;

  logic [IW-1:0] g_prog[$];   // model of the stored program
  logic [IW-1:0] exp_q[$];    // expected proc_instr stream
  logic [IW-1:0] got;

  program_sequencer #(
    .INSTR_W        (IW),
    .DEPTH          (16),
    .CNT_W          (5),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_clear      (clear),
    .i_load_valid (load_valid),
    .i_load_instr (load_instr),
    .i_load_last  (load_last),
    .o_load_ready (load_ready),
    .i_run_req    (run_req),
    .o_proc_write (proc_write),
    .o_proc_instr (proc_instr),
    .o_proc_start (proc_start),
    .i_proc_done  (proc_done),
    .o_prog_len   (prog_len),
    .o_seq_ready  (seq_ready),
    .o_done       (done),
    .o_trunc      (trunc),
    .o_timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [IW-1:0] w, input logic last);
    load_valid = 1'b1;
    load_instr = w;
    load_last  = last;
    g_prog.push_back(w);
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
    load_instr = '0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    g_prog.delete();
  endtask

  task automatic push_expected();
    foreach (g_prog[i]) exp_q.push_back(g_prog[i]);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if ({load_ready, seq_ready, proc_write, proc_start, done, trunc, timeout} !== 7'b1000000) begin
      failures++;
      $display("FAIL reset_flags got=%b want=1000000",
               {load_ready, seq_ready, proc_write, proc_start, done, trunc, timeout});
    end
    checks++;
    if (prog_len !== 5'd0) begin
      failures++;
      $display("FAIL reset_prog_len got=%0d want=0", prog_len);
    end
    checks++;
    if (proc_instr !== '0) begin
      failures++;
      $display("FAIL reset_proc_instr got=%h want=0", proc_instr);
    end
  endtask

  task automatic test_load_run();
    load_word(23'h000001, 1'b0);
    load_word(23'h000002, 1'b0);
    load_word(23'h7FFFFF, 1'b1);
    checks++;
    if ({seq_ready, load_ready} !== 2'b10 || prog_len !== 5'd3) begin
      failures++;
      $display("FAIL load3_ready got seq=%b ld=%b len=%0d want seq=1 ld=0 len=3",
               seq_ready, load_ready, prog_len);
    end
    push_expected();
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      got = exp_q.pop_front();
      checks++;
      if (proc_write !== 1'b1 || proc_instr !== got) begin
        failures++;
        $display("FAIL stream3[%0d] got w=%b i=%h want w=1 i=%h", k, proc_write, proc_instr, got);
      end
      tick();
    end
    checks++;
    if ({proc_start, proc_write} !== 2'b10 || proc_instr !== '0) begin
      failures++;
      $display("FAIL start_pulse got st=%b w=%b i=%h want st=1 w=0 i=0",
               proc_start, proc_write, proc_instr);
    end
    tick();
    checks++;
    if (proc_start !== 1'b0) begin
      failures++;
      $display("FAIL start_one_cycle got=%b want=0", proc_start);
    end
    repeat (3) tick();
    checks++;
    if ({done, seq_ready} !== 2'b00) begin
      failures++;
      $display("FAIL run_wait got done=%b seq=%b want 00", done, seq_ready);
    end
    proc_done = 1'b1;
    tick();
    proc_done = 1'b0;
    checks++;
    if ({done, seq_ready} !== 2'b10) begin
      failures++;
      $display("FAIL done_pulse got done=%b seq=%b want 10", done, seq_ready);
    end
    tick();
    checks++;
    if ({done, seq_ready} !== 2'b01) begin
      failures++;
      $display("FAIL back_to_ready got done=%b seq=%b want 01", done, seq_ready);
    end
  endtask

  task automatic test_rerun();
    push_expected();
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      got = exp_q.pop_front();
      checks++;
      if (proc_write !== 1'b1 || proc_instr !== got) begin
        failures++;
        $display("FAIL replay[%0d] got w=%b i=%h want w=1 i=%h", k, proc_write, proc_instr, got);
      end
      tick();
    end
    checks++;
    if (proc_start !== 1'b1) begin
      failures++;
      $display("FAIL replay_start got=%b want=1", proc_start);
    end
    tick();
    proc_done = 1'b1;
    tick();
    proc_done = 1'b0;
    tick();
    checks++;
    if (seq_ready !== 1'b1 || prog_len !== 5'd3) begin
      failures++;
      $display("FAIL replay_retained got seq=%b len=%0d want seq=1 len=3", seq_ready, prog_len);
    end
  endtask

  task automatic test_trunc();
    do_clear();
    for (int k = 0; k < 16; k++) load_word(IW'($urandom), 1'b0);
    checks++;
    if ({trunc, load_ready, seq_ready} !== 3'b101 || prog_len !== 5'd16) begin
      failures++;
      $display("FAIL trunc_flags got tr=%b ld=%b seq=%b len=%0d want tr=1 ld=0 seq=1 len=16",
               trunc, load_ready, seq_ready, prog_len);
    end
    load_word(23'h123456, 1'b1);   // ignored outside IDLE
    void'(g_prog.pop_back());
    checks++;
    if (prog_len !== 5'd16) begin
      failures++;
      $display("FAIL load_ignored_ready got len=%0d want=16", prog_len);
    end
    push_expected();
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    for (int k = 0; k < 16; k++) begin
      got = exp_q.pop_front();
      checks++;
      if (proc_write !== 1'b1 || proc_instr !== got) begin
        failures++;
        $display("FAIL stream16[%0d] got w=%b i=%h want w=1 i=%h", k, proc_write, proc_instr, got);
      end
      tick();
    end
    checks++;
    if (proc_start !== 1'b1) begin
      failures++;
      $display("FAIL trunc_start got=%b want=1", proc_start);
    end
    tick();
    proc_done = 1'b1;
    tick();
    proc_done = 1'b0;
    tick();
    checks++;
    if ({seq_ready, trunc} !== 2'b11) begin
      failures++;
      $display("FAIL trunc_kept got seq=%b tr=%b want 11", seq_ready, trunc);
    end
  endtask

  task automatic test_clear();
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    checks++;
    if (proc_write !== 1'b1 || proc_instr !== g_prog[0]) begin
      failures++;
      $display("FAIL clr_xfer0 got w=%b i=%h want w=1 i=%h", proc_write, proc_instr, g_prog[0]);
    end
    tick();
    checks++;
    if (proc_write !== 1'b1 || proc_instr !== g_prog[1]) begin
      failures++;
      $display("FAIL clr_xfer1 got w=%b i=%h want w=1 i=%h", proc_write, proc_instr, g_prog[1]);
    end
    do_clear();
    checks++;
    if ({proc_write, load_ready, seq_ready, trunc} !== 4'b0100 || prog_len !== 5'd0
        || proc_instr !== '0) begin
      failures++;
      $display("FAIL clear_abort got w=%b ld=%b seq=%b tr=%b len=%0d i=%h want 0100 len=0 i=0",
               proc_write, load_ready, seq_ready, trunc, prog_len, proc_instr);
    end
    tick();
    checks++;
    if (proc_write !== 1'b0) begin
      failures++;
      $display("FAIL clear_stays_idle got w=%b want=0", proc_write);
    end
  endtask

  task automatic test_ignored();
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    tick();
    checks++;
    if ({load_ready, seq_ready, proc_write, proc_start, done} !== 5'b10000) begin
      failures++;
      $display("FAIL run_in_idle got=%b want=10000",
               {load_ready, seq_ready, proc_write, proc_start, done});
    end
    load_word(23'h0000AA, 1'b0);
    load_word(23'h0000BB, 1'b1);
    proc_done = 1'b1;
    tick();
    proc_done = 1'b0;
    checks++;
    if ({seq_ready, done, proc_start, proc_write} !== 4'b1000 || prog_len !== 5'd2) begin
      failures++;
      $display("FAIL done_in_ready got seq=%b dn=%b st=%b w=%b len=%0d want 1000 len=2",
               seq_ready, done, proc_start, proc_write, prog_len);
    end
  endtask

  task automatic test_reset_in_run();
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    repeat (4) tick();   // 2 writes, start, now in RUN
    reset = 1'b1;
    tick();
    reset = 1'b0;
    g_prog.delete();
    checks++;
    if ({load_ready, seq_ready, proc_write, proc_start, done, trunc, timeout} !== 7'b1000000
        || prog_len !== 5'd0) begin
      failures++;
      $display("FAIL reset_in_run got=%b len=%0d want=1000000 len=0",
               {load_ready, seq_ready, proc_write, proc_start, done, trunc, timeout}, prog_len);
    end
  endtask

`ifdef PROG_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int seen_done;
    seen_done = 0;
    load_word(23'h000055, 1'b1);
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    tick();              // start cycle
    tick();              // first RUN cycle
    for (int k = 0; k < 7; k++) begin
      if (done === 1'b1) seen_done++;
      tick();
    end
    checks++;
    if (timeout !== 1'b0) begin
      failures++;
      $display("FAIL timeout_early got=%b want=0", timeout);
    end
    tick();
    checks++;
    if ({timeout, seq_ready, done} !== 3'b110 || seen_done != 0) begin
      failures++;
      $display("FAIL timeout_fire got to=%b seq=%b dn=%b dones=%0d want 110 dones=0",
               timeout, seq_ready, done, seen_done);
    end
  endtask
`endif

  initial begin
    checks     = 0;
    failures   = 0;
    reset      = 1'b0;
    clear      = 1'b0;
    load_valid = 1'b0;
    load_instr = '0;
    load_last  = 1'b0;
    run_req    = 1'b0;
    proc_done  = 1'b0;
    test_reset();
    test_load_run();
    test_rerun();
    test_trunc();
    test_clear();
    test_ignored();
    test_reset_in_run();
`ifdef PROG_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d left want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
